codec_init_sequencer: RTL and testbench

//  Top-level sequencer for codec_programmer. After power-up or START it walks the codec command

---
 rtl/codec_init_sequencer_pkg.sv | 42 ++++
 rtl/codec_init_sequencer_sync2.sv | 25 ++
 rtl/codec_init_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_codec_init_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/codec_init_sequencer_pkg.sv
// Shared codec command indices, FSM state encoding and sizing helpers
// for the codec init sequencer and codec_programmer.
package codec_init_sequencer_pkg;

  localparam int CODEC_CMD_W = 4;

  localparam logic [CODEC_CMD_W-1:0] CMD_DUMMY   = 4'd0;
  localparam logic [CODEC_CMD_W-1:0] SET_LIN_L   = 4'd1;
  localparam logic [CODEC_CMD_W-1:0] SET_LIN_R   = 4'd2;
  localparam logic [CODEC_CMD_W-1:0] SET_HP_L    = 4'd3;
  localparam logic [CODEC_CMD_W-1:0] SET_HP_R    = 4'd4;
  localparam logic [CODEC_CMD_W-1:0] ANA_PATH    = 4'd5;
  localparam logic [CODEC_CMD_W-1:0] DIG_PATH    = 4'd6;
  localparam logic [CODEC_CMD_W-1:0] PWR_CTRL    = 4'd7;
  localparam logic [CODEC_CMD_W-1:0] DIG_FMT     = 4'd8;
  localparam logic [CODEC_CMD_W-1:0] DIG_ACT     = 4'd9;
  localparam logic [CODEC_CMD_W-1:0] SAMPLE_CTRL = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETTLE,
    S_ISSUE,
    S_WAIT_ACC,
    S_WAIT_DONE,
    S_CHECK,
    S_GAP,
    S_DONE,
    S_FAIL
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bit width able to hold 0..v-1, never narrower than one bit.
  function automatic int width_of(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/codec_init_sequencer_sync2.sv
// Two-flop synchronizer for single-bit async inputs.
// Ports: clk, rst (async high), d (async in), q (synced out).
module codec_init_sequencer_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/codec_init_sequencer.sv
// Walks the codec command list issuing one programmer write per command,
// with retry on NACK/timeout. Ports: CLK, RST, START, CMD/GO to the
// programmer, READY/ACK from it, BUSY/DONE/ERROR/ERR_CMD status.
module codec_init_sequencer
  import codec_init_sequencer_pkg::*;
#(
  parameter int CMD_W       = 4,
  parameter int FIRST_CMD   = 1,
  parameter int LAST_CMD    = 10,
  parameter int SETTLE_CYC  = 1024,
  parameter int GAP_CYC     = 64,
  parameter int TIMEOUT_CYC = 65535,
  parameter int MAX_RETRY   = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic [CMD_W-1:0] CMD,
  output logic             GO,
  input  logic             READY,
  input  logic             ACK,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic [CMD_W-1:0] ERR_CMD
);

  localparam int TMR_W =
    width_of(max3(SETTLE_CYC, GAP_CYC, TIMEOUT_CYC) + 1);
  localparam int RTY_W = width_of(MAX_RETRY + 1);

  // Timer counts down to zero, so each phase loads its length minus one.
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD    = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_LD    = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [CMD_W-1:0] CMD_FIRST = CMD_W'(FIRST_CMD);
  localparam logic [CMD_W-1:0] CMD_LAST  = CMD_W'(LAST_CMD);

  logic rdy_s;
  logic ack_s;

  codec_init_sequencer_sync2 u_sync_ready (
    .clk (CLK),
    .rst (RST),
    .d   (READY),
    .q   (rdy_s)
  );

  codec_init_sequencer_sync2 u_sync_ack (
    .clk (CLK),
    .rst (RST),
    .d   (ACK),
    .q   (ack_s)
  );

  state_t           state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [CMD_W-1:0] err_cmd_q, err_cmd_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             go_q, go_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tmo_q, tmo_d;
  logic             tmr_zero;

  assign tmr_zero = (tmr_q == '0);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    err_cmd_d = err_cmd_q;
    rty_d     = rty_q;
    tmr_d     = tmr_q;
    go_d      = go_q;
    done_d    = done_q;
    err_d     = err_q;
    tmo_d     = tmo_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (START) begin
          state_d   = S_SETTLE;
          tmr_d     = SETTLE_LD;
          done_d    = 1'b0;
          err_d     = 1'b0;
          err_cmd_d = '0;
        end
      end
      S_SETTLE: begin
        if (tmr_zero) begin
          cmd_d   = CMD_FIRST;
          rty_d   = '0;
          state_d = S_ISSUE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_ISSUE: begin
        if (rdy_s) begin
          go_d    = 1'b1;
          tmo_d   = 1'b0;
          tmr_d   = TMO_LD;
          state_d = S_WAIT_ACC;
        end
      end
      S_WAIT_ACC: begin
        if (!rdy_s) begin
          go_d    = 1'b0;
          tmr_d   = TMO_LD;
          state_d = S_WAIT_DONE;
        end else if (tmr_zero) begin
          // Never accepted: withdraw the request and retry via CHECK.
          go_d    = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_CHECK;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (rdy_s) begin
          state_d = S_CHECK;
        end else if (tmr_zero) begin
          tmo_d   = 1'b1;
          state_d = S_CHECK;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_CHECK: begin
        if (ack_s && !tmo_q) begin
          if (cmd_q == CMD_LAST) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cmd_d   = cmd_q + 1'b1;
            rty_d   = '0;
            tmr_d   = GAP_LD;
            state_d = S_GAP;
          end
        end else if (rty_q < RTY_MAX) begin
          rty_d   = rty_q + 1'b1;
          tmr_d   = GAP_LD;
          state_d = S_GAP;
        end else begin
          err_d     = 1'b1;
          err_cmd_d = cmd_q;
          state_d   = S_FAIL;
        end
      end
      S_GAP: begin
        if (tmr_zero) begin
          state_d = S_ISSUE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: begin
        go_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = !(state_d inside {S_IDLE, S_DONE, S_FAIL});
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_SETTLE;
      tmr_q     <= SETTLE_LD;
      cmd_q     <= '0;
      err_cmd_q <= '0;
      rty_q     <= '0;
      go_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cmd_q     <= cmd_d;
      err_cmd_q <= err_cmd_d;
      rty_q     <= rty_d;
      go_q      <= go_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign CMD     = cmd_q;
  assign GO      = go_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERROR   = err_q;
  assign ERR_CMD = err_cmd_q;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Directed bench for codec_init_sequencer with a behavioural
// codec_programmer model (accept, busy, ACK/NACK, stuck-ready).
module tb_codec_init_sequencer;

  logic       CLK   = 1'b0;
  logic       RST   = 1'b1;
  logic       START = 1'b0;
  logic       READY = 1'b1;
  logic       ACK   = 1'b0;
  logic [3:0] CMD;
  logic [3:0] ERR_CMD;
  logic       GO;
  logic       BUSY;
  logic       DONE;
  logic       ERROR;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  codec_init_sequencer #(
    .CMD_W       (4),
    .FIRST_CMD   (1),
    .LAST_CMD    (10),
    .SETTLE_CYC  (16),
    .GAP_CYC     (4),
    .TIMEOUT_CYC (40),
    .MAX_RETRY   (3)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .CMD     (CMD),
    .GO      (GO),
    .READY   (READY),
    .ACK     (ACK),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ERROR   (ERROR),
    .ERR_CMD (ERR_CMD)
  );

  int   mst = 0;
  int   mcnt = 0;
  logic [3:0] mc;
  int   att [16];
  int   log_c [64];
  int   log_n = 0;
  int   go_cnt = 0;
  logic go_prev = 1'b0;
  int   nack_cmd = 0;
  int   nack_n = 0;
  bit   stuck = 1'b0;
  bit   clr = 1'b0;

  always @(negedge CLK) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) att[i] = 0;
      log_n  = 0;
      go_cnt = 0;
    end
    if (RST) begin
      READY   = 1'b1;
      ACK     = 1'b0;
      mst     = 0;
      go_prev = 1'b0;
    end else begin
      if (GO && !go_prev) go_cnt++;
      go_prev = GO;
      if (mst == 0) begin
        if (GO && READY && !stuck) begin
          mc = CMD;
          att[mc]++;
          if (log_n < 64) log_c[log_n] = int'(CMD);
          log_n++;
          READY = 1'b0;
          mcnt  = 6;
          mst   = 1;
        end
      end else begin
        mcnt--;
        if (mcnt == 0) begin
          ACK   = !(int'(mc) == nack_cmd && att[mc] <= nack_n);
          READY = 1'b1;
          mst   = 0;
        end
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_model();
    clr = 1'b1;
    @(negedge CLK);
    #1 clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(DONE || ERROR) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    #1;
    check(tag, 32'(n < 3000), 1);
  endtask

  initial begin
    int found;

    // Reset values
    #12;
    check("rst_cmd", 32'(CMD), 0);
    check("rst_go", 32'(GO), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_done", 32'(DONE), 0);
    check("rst_error", 32'(ERROR), 0);
    check("rst_errcmd", 32'(ERR_CMD), 0);
    clr_model();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("auto_busy", 32'(BUSY), 1);

    // 1: auto-init, all ACKed
    wait_end("t1_wait");
    check("t1_done", 32'(DONE), 1);
    check("t1_error", 32'(ERROR), 0);
    check("t1_busy", 32'(BUSY), 0);
    check("t1_go_cnt", 32'(go_cnt), 10);
    for (int i = 0; i < 10; i++)
      check($sformatf("t1_order%0d", i), 32'(log_c[i]), 32'(i + 1));

    // 2: CMD 5 NACKed twice then ACKed
    nack_cmd = 5;
    nack_n   = 2;
    clr_model();
    pulse_start();
    wait_end("t2_wait");
    check("t2_done", 32'(DONE), 1);
    check("t2_error", 32'(ERROR), 0);
    check("t2_att5", 32'(att[5]), 3);
    check("t2_go_cnt", 32'(go_cnt), 12);

    // 3: CMD 7 always NACKed
    nack_cmd = 7;
    nack_n   = 99;
    clr_model();
    pulse_start();
    wait_end("t3_wait");
    check("t3_error", 32'(ERROR), 1);
    check("t3_done", 32'(DONE), 0);
    check("t3_errcmd", 32'(ERR_CMD), 7);
    check("t3_att7", 32'(att[7]), 4);
    check("t3_att8", 32'(att[8]), 0);
    check("t3_busy", 32'(BUSY), 0);

    // 4: programmer never accepts
    nack_cmd = 0;
    stuck    = 1'b1;
    clr_model();
    pulse_start();
    wait_end("t4_wait");
    check("t4_error", 32'(ERROR), 1);
    check("t4_errcmd", 32'(ERR_CMD), 1);
    check("t4_go_cnt", 32'(go_cnt), 4);
    check("t4_go_low", 32'(GO), 0);

    // 5: START clears flags; START while busy ignored
    stuck = 1'b0;
    clr_model();
    pulse_start();
    check("t5_err_clr", 32'(ERROR), 0);
    check("t5_errcmd_clr", 32'(ERR_CMD), 0);
    check("t5_busy", 32'(BUSY), 1);
    repeat (60) @(negedge CLK);
    pulse_start();
    wait_end("t5_wait_a");
    check("t5_go_cnt_a", 32'(go_cnt), 10);
    check("t5_done_a", 32'(DONE), 1);
    clr_model();
    pulse_start();
    check("t5_done_clr", 32'(DONE), 0);
    wait_end("t5_wait_b");
    check("t5_go_cnt_b", 32'(go_cnt), 10);
    check("t5_done_b", 32'(DONE), 1);

    // 6: async reset while waiting for CMD 3 to finish
    clr_model();
    pulse_start();
    found = 0;
    for (int n = 0; n < 2000 && found == 0; n++) begin
      @(negedge CLK);
      #1;
      if (att[3] == 1 && mst == 1 && !GO && CMD == 4'd3) found = 1;
    end
    check("t6_window", 32'(found), 1);
    #1 RST = 1'b1;
    #1;
    check("t6_rst_go", 32'(GO), 0);
    check("t6_rst_busy", 32'(BUSY), 0);
    check("t6_rst_cmd", 32'(CMD), 0);
    @(negedge CLK);
    #1 RST = 1'b0;
    clr_model();
    wait_end("t6_wait");
    check("t6_first", 32'(log_c[0]), 1);
    check("t6_go_cnt", 32'(go_cnt), 10);
    check("t6_done", 32'(DONE), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
